// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates one fetch and one data requester onto a single memory port, one transaction in flight.
// Latency: grant is combinational in IDLE; the response appears LAT cycles after the grant; next grant at T+LAT+1.
// Backpressure: requesters hold req/payload until gnt; no grants while busy or in reset; contended data grants are capped by STARVE_MAX.
//
// Ports:
//   clk, rst_b                         clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt           fetch request, word address taken from bits [31:2]
//   if_rvalid/if_rdata                 fetch response pulse and data
//   d_req/d_we/d_be/d_addr/d_wdata     data request (load when d_we=0, store when d_we=1)
//   d_gnt, d_rvalid/d_rdata            data accept, completion pulse, load data
//   m_addr/m_we/m_be/m_wdata/m_rdata   memory port, driven only in the grant cycle
//   busy                               a transaction is outstanding
module mem_port_arbiter #(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT_C    = 3'(LAT);
    localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] lat_cnt, lat_cnt_nxt;
    logic [2:0] starve_cnt, starve_nxt;
    logic       store_q, store_nxt;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 3'd0;
            store_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_nxt;
            store_q    <= store_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        starve_nxt  = starve_cnt;
        store_nxt   = store_q;
        if_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = 32'd0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = 32'd0;
        m_addr      = 32'd0;
        m_we        = 1'b0;
        m_be        = 4'd0;
        m_wdata     = 32'd0;
        busy        = 1'b0;

        // Every output stays quiet while reset is asserted, even if the
        // state register still holds a pre-reset value this cycle.
        if (!rst_b) begin
            case (state)
                IDLE: begin
                    // Data wins contention until the fetch side has been
                    // passed over STARVE_MAX times in a row.
                    if (if_req && (!d_req || starve_cnt == STARVE_C)) begin
                        if_gnt      = 1'b1;
                        m_addr      = {if_addr[31:2], 2'b00};
                        starve_nxt  = 3'd0;
                        lat_cnt_nxt = LAT_C;
                        state_nxt   = WAIT_IF;
                    end else if (d_req) begin
                        d_gnt       = 1'b1;
                        m_addr      = {d_addr[31:2], 2'b00};
                        if (d_we) begin
                            m_we    = |d_be;
                            m_be    = d_be;
                            m_wdata = d_wdata;
                        end
                        store_nxt   = d_we;
                        lat_cnt_nxt = LAT_C;
                        state_nxt   = WAIT_D;
                        if (!if_req)
                            starve_nxt = 3'd0;
                        else if (starve_cnt < STARVE_C)
                            starve_nxt = starve_cnt + 3'd1;
                    end
                end
                WAIT_IF: begin
                    busy = 1'b1;
                    if (lat_cnt == 3'd1) begin
                        if_rvalid   = 1'b1;
                        if_rdata    = m_rdata;
                        lat_cnt_nxt = 3'd0;
                        state_nxt   = IDLE;
                    end else begin
                        lat_cnt_nxt = lat_cnt - 3'd1;
                    end
                end
                WAIT_D: begin
                    busy = 1'b1;
                    if (lat_cnt == 3'd1) begin
                        d_rvalid    = 1'b1;
                        d_rdata     = store_q ? 32'd0 : m_rdata;
                        lat_cnt_nxt = 3'd0;
                        state_nxt   = IDLE;
                    end else begin
                        lat_cnt_nxt = lat_cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: exercises two arbiter instances (LAT=1 and LAT=3, STARVE_MAX=2) against a response scoreboard.
// Latency: responses are expected exactly LAT cycles after each observed grant.
// Backpressure: requests are held until granted; the bench waits a bounded number of cycles for each grant.
module tb_mem_port_arbiter;

    typedef struct {
        int          cyc;
        bit          is_if;
        logic [31:0] rdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [3:0]  d_be      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic [31:0] m_addr    [2];
    logic        m_we      [2];
    logic [3:0]  m_be      [2];
    logic [31:0] m_wdata   [2];
    logic [31:0] m_rdata   [2];
    logic        busy      [2];

    ev_t sb0[$];
    ev_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input int i, input int c);
        return 32'h3C00_0000 ^ (32'(c) * 32'h0001_0101) ^ 32'(i);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    assign m_rdata[0] = memf(0, cyc);
    assign m_rdata[1] = memf(1, cyc);

    mem_port_arbiter #(.LAT(1), .STARVE_MAX(2)) u_lat1 (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_be(d_be[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .m_addr(m_addr[0]), .m_we(m_we[0]), .m_be(m_be[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.LAT(3), .STARVE_MAX(2)) u_lat3 (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_be(d_be[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .m_addr(m_addr[1]), .m_we(m_we[1]), .m_be(m_be[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant on instance i, check the memory drive in
    // that cycle and optionally schedule the expected response.
    task automatic await_gnt(input int i, input bit want_if, input logic [31:0] exp_addr,
                             input bit exp_we, input logic [3:0] exp_be, input bit chk_wd,
                             input logic [31:0] exp_wd, input bit is_store, input bit push,
                             output int t);
        bit  seen = 1'b0;
        int  n = 0;
        ev_t e;
        t = -1;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (if_gnt[i] || d_gnt[i]) begin
                seen = 1'b1;
                t = cyc;
                chk("gnt_kind", {if_gnt[i], d_gnt[i]}, {want_if, !want_if});
                chk("m_addr", m_addr[i], exp_addr);
                chk("m_we_be", {m_we[i], m_be[i]}, {exp_we, exp_be});
                if (chk_wd) chk("m_wdata", m_wdata[i], exp_wd);
                if (push) begin
                    e.cyc   = cyc + lat_of(i);
                    e.is_if = want_if;
                    e.rdata = is_store ? 32'd0 : memf(i, e.cyc);
                    if (i == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                end
            end
            n++;
        end
        if (!seen) chk("gnt_timeout", 0, 1);
    endtask

    // Response scoreboard plus per-cycle protocol checks on both instances.
    always @(negedge clk) begin
        ev_t         e;
        bit          hv;
        bit          exp_if;
        bit          exp_d;
        logic [31:0] exp_rd;
        for (int i = 0; i < 2; i++) begin
            hv = 1'b0;
            e  = '{cyc: 0, is_if: 1'b0, rdata: 32'd0};
            if (i == 0) begin
                if (sb0.size() > 0 && sb0[0].cyc == cyc) begin e = sb0.pop_front(); hv = 1'b1; end
            end else begin
                if (sb1.size() > 0 && sb1[0].cyc == cyc) begin e = sb1.pop_front(); hv = 1'b1; end
            end
            exp_if = hv && e.is_if;
            exp_d  = hv && !e.is_if;
            exp_rd = hv ? e.rdata : 32'd0;
            chk("if_rvalid", if_rvalid[i], exp_if);
            chk("if_rdata", if_rdata[i], exp_if ? exp_rd : 32'd0);
            chk("d_rvalid", d_rvalid[i], exp_d);
            chk("d_rdata", d_rdata[i], exp_d ? exp_rd : 32'd0);
            chk("gnt_excl", if_gnt[i] & d_gnt[i], 0);
            chk("gnt_busy", (if_gnt[i] | d_gnt[i]) & busy[i], 0);
            if (!(if_gnt[i] || d_gnt[i]))
                chk("m_idle", {m_addr[i], m_wdata[i], m_we[i], m_be[i]}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, prev;
        bit want;
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = 32'd0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_be[i] = 4'd0;
            d_addr[i] = 32'd0; d_wdata[i] = 32'd0;
        end

        // Reset with both requesters asking: nothing may be granted.
        rst_b = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin if_req[i] = 1'b1; d_req[i] = 1'b1; end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                chk("rst_quiet", {if_gnt[i], d_gnt[i], busy[i]}, 0);
        end
        tick();
        for (int i = 0; i < 2; i++) begin if_req[i] = 1'b0; d_req[i] = 1'b0; end
        tick();
        rst_b = 1'b0;

        // LAT=1 single fetch with unaligned address.
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0106;
        await_gnt(0, 1, 32'h0000_0104, 0, 4'd0, 0, 0, 0, 1, t);
        tick();
        if_req[0] = 1'b0;
        @(negedge clk); chk("busy_wait", busy[0], 1);
        tick();
        @(negedge clk); chk("busy_idle", busy[0], 0);

        // LAT=1 partial store.
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0011;
        d_addr[0] = 32'h40; d_wdata[0] = 32'hDEAD_BEEF;
        await_gnt(0, 0, 32'h40, 1, 4'b0011, 1, 32'hDEAD_BEEF, 1, 1, t);
        tick();
        d_req[0] = 1'b0;

        // LAT=1 load, high address with low bits set.
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'b1111; d_addr[0] = 32'h8000_0013;
        await_gnt(0, 0, 32'h8000_0010, 0, 4'd0, 0, 0, 0, 1, t);
        tick();
        d_req[0] = 1'b0;

        // Zero-enable store: granted and completed, but no write strobe.
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0000;
        d_addr[0] = 32'h47; d_wdata[0] = 32'h1234_5678;
        await_gnt(0, 0, 32'h44, 0, 4'd0, 1, 32'h1234_5678, 1, 1, t);
        tick();
        d_req[0] = 1'b0; d_we[0] = 1'b0;

        // Continuous contention: D, D, IF repeating, two cycles apart.
        tick();
        if_addr[0] = 32'h1000; d_addr[0] = 32'h2000; d_we[0] = 1'b0;
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        prev = -1;
        for (int k = 0; k < 9; k++) begin
            want = (k % 3 == 2);
            await_gnt(0, want, want ? 32'h1000 : 32'h2000, 0, 4'd0, 0, 0, 0, 1, t);
            if (k > 0) chk("gnt_spacing", t - prev, 2);
            prev = t;
        end
        tick();
        if_req[0] = 1'b0; d_req[0] = 1'b0;

        // An uncontended data grant clears the starvation count.
        tick();
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        await_gnt(0, 0, 32'h2000, 0, 4'd0, 0, 0, 0, 1, t);
        tick();
        if_req[0] = 1'b0;
        await_gnt(0, 0, 32'h2000, 0, 4'd0, 0, 0, 0, 1, t);
        tick();
        if_req[0] = 1'b1;
        await_gnt(0, 0, 32'h2000, 0, 4'd0, 0, 0, 0, 1, t);
        await_gnt(0, 0, 32'h2000, 0, 4'd0, 0, 0, 0, 1, t);
        await_gnt(0, 1, 32'h1000, 0, 4'd0, 0, 0, 0, 1, t);
        tick();
        if_req[0] = 1'b0; d_req[0] = 1'b0;

        // LAT=3 load with request held: regrant exactly four cycles later.
        tick();
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h300;
        await_gnt(1, 0, 32'h300, 0, 4'd0, 0, 0, 0, 1, t);
        await_gnt(1, 0, 32'h300, 0, 4'd0, 0, 0, 0, 1, t2);
        chk("lat3_regnt", t2 - t, 4);

        // Request raised while busy and dropped before any grant.
        tick();
        tick();
        d_req[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("dropped_req", {if_gnt[1], d_gnt[1]}, 0);
        end

        // Reset one cycle into a LAT=3 fetch: no response, immediate regrant.
        tick();
        if_req[1] = 1'b1; if_addr[1] = 32'h5008;
        await_gnt(1, 1, 32'h5008, 0, 4'd0, 0, 0, 0, 0, t);
        tick();
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {if_gnt[1], d_gnt[1], busy[1], if_rvalid[1], m_addr[1]}, 0);
        tick();
        @(negedge clk);
        chk("rst_mid_outs2", {if_gnt[1], d_gnt[1], busy[1], if_rvalid[1], m_addr[1]}, 0);
        tick();
        rst_b = 1'b0;
        await_gnt(1, 1, 32'h5008, 0, 4'd0, 0, 0, 0, 1, t2);
        chk("rst_first_gnt", t2 - t, 3);
        tick();
        if_req[1] = 1'b0;

        repeat (8) tick();
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
